// File: rtl/normaliser_pkg.sv
// rtl/normaliser_pkg.sv - shared types, defaults and helpers for the denormaliser
package normaliser_pkg;

  localparam int unsigned DEF_IN_SIZE = 50;
  localparam int unsigned DEF_STEP    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Unsigned minimum, used for shift-distance and position clamping
  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/shift_step_sticky.sv
// rtl/shift_step_sticky.sv - one bounded right-shift step with lost-bits OR
module shift_step_sticky #(
  parameter int unsigned WIDTH = 50,
  parameter int unsigned S_W   = 4
) (
  input  logic [WIDTH-1:0] value,
  input  logic [S_W-1:0]   s,
  output logic [WIDTH-1:0] shifted,
  output logic             lost
);

  logic [WIDTH-1:0] low_mask;

  // Shift right by s with zero fill; lost is the OR of the s bits falling off bit 0
  always_comb begin
    low_mask = ~({WIDTH{1'b1}} << s);
    shifted  = value >> s;
    lost     = |(value & low_mask);
  end

endmodule

// File: rtl/denormaliser_iter.sv
// rtl/denormaliser_iter.sv - iterative right-shift denormaliser with sticky output
module denormaliser_iter
  import normaliser_pkg::*;
#(
  parameter int unsigned IN_SIZE  = DEF_IN_SIZE,
  parameter int unsigned POS_SIZE = $clog2(IN_SIZE),
  parameter int unsigned STEP     = DEF_STEP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_SIZE-1:0]  in_mant,
  input  logic [POS_SIZE-1:0] in_pos,
  input  logic                in_zero,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IN_SIZE-1:0]  out_mant,
  output logic                out_sticky,
  output logic                busy
);

  localparam int unsigned S_W     = $clog2(STEP + 1);
  localparam int unsigned MAX_POS = IN_SIZE - 1;

  state_t              state_q, state_d;
  logic [IN_SIZE-1:0]  value_q, value_d;
  logic                sticky_q, sticky_d;
  logic [POS_SIZE-1:0] r_q, r_d;
  logic                in_ready_q, in_ready_d;

  logic [S_W-1:0]      step_s;
  logic [IN_SIZE-1:0]  step_value;
  logic                step_lost;
  logic [POS_SIZE-1:0] r_accept;

  // Per-cycle shift distance and the remaining count for a fresh operand (position clamps to MSB)
  always_comb begin
    step_s   = S_W'(min_u(32'(r_q), STEP));
    r_accept = POS_SIZE'(MAX_POS - min_u(32'(in_pos), MAX_POS));
  end

  shift_step_sticky #(
    .WIDTH (IN_SIZE),
    .S_W   (S_W)
  ) u_step (
    .value   (value_q),
    .s       (step_s),
    .shifted (step_value),
    .lost    (step_lost)
  );

  // Next-state and datapath updates; in_ready is registered so it follows the next state
  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    sticky_d = sticky_q;
    r_d      = r_q;
    case (state_q)
      ST_IDLE: begin
        if (in_ready_q && in_valid) begin
          sticky_d = 1'b0;
          if (in_zero) begin
            value_d = '0;
            r_d     = '0;
            state_d = ST_DONE;
          end else begin
            value_d = in_mant;
            r_d     = r_accept;
            state_d = (r_accept == '0) ? ST_DONE : ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        value_d  = step_value;
        sticky_d = sticky_q | step_lost;
        r_d      = r_q - POS_SIZE'(step_s);
        if (r_d == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers; reset discards any operation in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      value_q    <= '0;
      sticky_q   <= 1'b0;
      r_q        <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      sticky_q   <= sticky_d;
      r_q        <= r_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign out_mant   = value_q;
  assign out_sticky = sticky_q;

endmodule

// File: tb/tb_denormaliser_iter.sv
// tb/tb_denormaliser_iter.sv - scoreboard bench for denormaliser_iter
module tb_denormaliser_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [49:0] in_mant = '0;
  logic [5:0]  in_pos = '0;
  logic        in_zero = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [49:0] out_mant;
  logic        out_sticky;
  logic        busy;

  denormaliser_iter dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mant    (in_mant),
    .in_pos     (in_pos),
    .in_zero    (in_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_mant   (out_mant),
    .out_sticky (out_sticky),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [49:0] mant;
    logic        sticky;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [49:0] bitv(input int i);
    logic [49:0] one;
    one = 50'd1;
    return one << i;
  endfunction

  // Drive one request; k is the number of edges after the accept edge until out_valid
  task automatic send(input logic [49:0] m, input logic [5:0] p, input logic z, input bit push,
                      input logic [49:0] em, input logic es, input int k);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; in_mant = m; in_pos = p; in_zero = z;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      $display("FAIL accept_timeout: in_ready stayed %0b required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_mant = ~m; in_pos = ~p; in_zero = ~z;
    if (push) q.push_back('{mant: em, sticky: es, lat: cyc + k});
  endtask

  // Monitor: checks first-valid latency, holding under backpressure, and data at handshake
  logic        prev_v = 1'b0;
  logic [49:0] hold_m;
  logic        hold_s;
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL spurious_valid: out_valid=%0b with nothing outstanding, required 0", out_valid);
      end else begin
        if (!prev_v) check("latency", 64'(cyc), 64'(q[0].lat));
        else begin
          check("hold_mant", 64'(out_mant), 64'(hold_m));
          check("hold_sticky", 64'(out_sticky), 64'(hold_s));
        end
        if (out_ready) begin
          check("out_mant", 64'(out_mant), 64'(q[0].mant));
          check("out_sticky", 64'(out_sticky), 64'(q[0].sticky));
          void'(q.pop_front());
        end
      end
      hold_m = out_mant;
      hold_s = out_sticky;
    end
    prev_v = !rst && out_valid && !out_ready;
  end

  initial begin
    int n;
    logic [49:0] ones;
    logic [49:0] pt;
    ones = '1;
    pt   = bitv(49) | 50'h12345;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_mant", 64'(out_mant), 0);
    check("rst_busy", 64'(busy), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ready_before_edge", 64'(in_ready), 0);
    @(negedge clk);
    check("ready_after_edge", 64'(in_ready), 1);

    // Reset in the middle of a long shift
    send(bitv(49), 6'd0, 1'b0, 1'b0, '0, 1'b0, 0);
    @(posedge clk); @(posedge clk); #1;
    check("midshift_busy_before_rst", 64'(busy), 1);
    rst = 1'b1; #1;
    check("midrst_out_mant", 64'(out_mant), 0);
    check("midrst_out_sticky", 64'(out_sticky), 0);
    check("midrst_in_ready", 64'(in_ready), 0);
    check("midrst_out_valid", 64'(out_valid), 0);
    check("midrst_busy", 64'(busy), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_before_edge", 64'(in_ready), 0);
    @(negedge clk);
    check("midrst_ready_after_edge", 64'(in_ready), 1);
    check("midrst_no_stale_valid", 64'(out_valid), 0);
    repeat (8) @(negedge clk);

    // Multi-step with sticky: R=9
    send(bitv(49) | 50'd1, 6'd40, 1'b0, 1'b1, bitv(40), 1'b1, 2);
    // Exact step multiple: R=16
    send(bitv(49) | bitv(16), 6'd33, 1'b0, 1'b1, bitv(33) | 50'd1, 1'b0, 2);
    // Pass-through and clamped position
    send(pt, 6'd49, 1'b0, 1'b1, pt, 1'b0, 0);
    send(pt, 6'd63, 1'b0, 1'b1, pt, 1'b0, 0);
    // Zero operand
    send(ones, 6'd0, 1'b1, 1'b1, '0, 1'b0, 0);

    // Maximum shift with backpressure and a request waiting during DONE
    @(posedge clk); #1 out_ready = 1'b0;
    send(ones, 6'd0, 1'b0, 1'b1, 50'd1, 1'b1, 7);
    fork
      send(bitv(49) | bitv(3), 6'd45, 1'b0, 1'b1, bitv(45), 1'b1, 1);
      begin
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
          n++;
          @(negedge clk);
        end
        check("bp_valid_seen", 64'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
          check("bp_in_ready_low", 64'(in_ready), 0);
          check("bp_busy", 64'(busy), 1);
          @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join

    n = 0;
    while (q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("queue_drained", 64'(q.size()), 0);
    repeat (2) @(negedge clk);
    check("idle_at_end", 64'(in_ready), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
